conv3x3_cfg: RTL

Parametrised 3x3 convolution engine, the next generation of the fixed Sobel edge stage in the video pipeline. It sits between the line-buffer window generator and the frame-buffer writer. It takes a 9-pixel window per cycle and produces one output pixel after a fixed pipeline latency. Two kernels are runtime-loadable through a shadow/active coefficient bank that commits only at start-of-frame. Selectable modes: Sobel-style edge threshold, or a single-kernel filter with shift and clamp.

---
 rtl/conv3x3_cfg.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/conv3x3_cfg.sv
// 3x3 convolution engine with shadow/active coefficient banks committed at start-of-frame.
// Optional CONV_ABS_MAG_EN builds the |sA|+|sB| edge path for mode 2; otherwise mode 2 acts as mode 0.
module conv3x3_cfg #(
  parameter int DW  = 12,
  parameter int KW  = 8,
  parameter int TW  = 2*(DW+KW+5)+1,
  parameter int SHW = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [9*DW-1:0] i_data,
  input  logic            i_valid,
  input  logic            i_sof,
  input  logic [1:0]      i_mode,
  input  logic [TW-1:0]   i_thresh,
  input  logic [SHW-1:0]  i_shift,
  input  logic            i_coef_we,
  input  logic            i_coef_sel,
  input  logic [3:0]      i_coef_addr,
  input  logic [KW-1:0]   i_coef_data,
  output logic [DW-1:0]   o_data,
  output logic            o_valid,
  output logic            o_cfg_pending
);

  localparam int PW = DW + KW + 1;
  localparam int SW = DW + KW + 5;

  typedef enum logic [1:0] {
    OP_EDGE = 2'd0,
    OP_FILT = 2'd1,
    OP_ABS  = 2'd2
  } op_t;

  function automatic logic signed [KW-1:0] sobel_tap(input logic sel, input logic [3:0] k);
    logic signed [KW-1:0] t;
    t = '0;
    if (!sel) begin
      case (k)
        4'd0, 4'd6: t = KW'(1);
        4'd2, 4'd8: t = KW'(-1);
        4'd3:       t = KW'(2);
        4'd5:       t = KW'(-2);
        default:    t = '0;
      endcase
    end else begin
      case (k)
        4'd0, 4'd2: t = KW'(1);
        4'd1:       t = KW'(2);
        4'd6, 4'd8: t = KW'(-1);
        4'd7:       t = KW'(-2);
        default:    t = '0;
      endcase
    end
    return t;
  endfunction

  function automatic logic signed [PW-1:0] tap_mul(input logic signed [KW-1:0] c,
                                                   input logic [DW-1:0] px);
    logic signed [PW-1:0] ce;
    logic signed [PW-1:0] pe;
    ce = {{(PW-KW){c[KW-1]}}, c};
    pe = {{(PW-DW){1'b0}}, px};
    return ce * pe;
  endfunction

  // coefficient banks
  logic signed [KW-1:0] active   [2][9];
  logic signed [KW-1:0] shadow   [2][9];
  logic signed [KW-1:0] coef_use [2][9];
  logic                 commit;
  logic                 coef_wr;

  assign commit  = i_sof && o_cfg_pending;
  assign coef_wr = i_coef_we && (i_coef_addr < 4'd9);

  // NBA semantics make a same-cycle commit copy the pre-write shadow
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned s = 0; s < 2; s++) begin
        for (int unsigned k = 0; k < 9; k++) begin
          active[s][k] <= sobel_tap(s[0], k[3:0]);
          shadow[s][k] <= sobel_tap(s[0], k[3:0]);
        end
      end
      o_cfg_pending <= 1'b0;
    end else begin
      if (commit)
        active <= shadow;
      if (coef_wr)
        shadow[i_coef_sel][i_coef_addr] <= i_coef_data;
      if (coef_wr)
        o_cfg_pending <= 1'b1;
      else if (commit)
        o_cfg_pending <= 1'b0;
    end
  end

  // a window arriving with the committing sof already belongs to the new frame
  op_t op_c;
  always_comb begin
    for (int unsigned s = 0; s < 2; s++) begin
      for (int unsigned k = 0; k < 9; k++) begin
        coef_use[s][k] = commit ? shadow[s][k] : active[s][k];
      end
    end
    op_c = OP_EDGE;
    case (i_mode)
      2'd1: op_c = OP_FILT;
`ifdef CONV_ABS_MAG_EN
      2'd2: op_c = OP_ABS;
`endif
      default: op_c = OP_EDGE;
    endcase
  end

  // S1: per-tap products
  logic signed [PW-1:0] prod_a [9];
  logic signed [PW-1:0] prod_b [9];
  always_comb begin
    for (int unsigned k = 0; k < 9; k++) begin
      prod_a[k] = tap_mul(coef_use[0][k], i_data[k*DW +: DW]);
      prod_b[k] = tap_mul(coef_use[1][k], i_data[k*DW +: DW]);
    end
  end

  logic                 v1, v2, v3;
  logic signed [PW-1:0] p1a [9];
  logic signed [PW-1:0] p1b [9];
  op_t                  op1, op2, op3;
  logic [TW-1:0]        th1, th2, th3;
  logic [SHW-1:0]       sh1, sh2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      v1      <= i_valid;
      v2      <= v1;
      v3      <= v2;
      o_valid <= v3;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      p1a <= prod_a;
      p1b <= prod_b;
      op1 <= op_c;
      th1 <= i_thresh;
      sh1 <= i_shift;
    end
  end

  // S2: kernel sums
  logic signed [SW-1:0] sum_a, sum_b;
  logic signed [SW-1:0] s2a, s2b;
  always_comb begin
    sum_a = '0;
    sum_b = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      sum_a = sum_a + {{(SW-PW){p1a[k][PW-1]}}, p1a[k]};
      sum_b = sum_b + {{(SW-PW){p1b[k][PW-1]}}, p1b[k]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (v1) begin
      s2a <= sum_a;
      s2b <= sum_b;
      op2 <= op1;
      th2 <= th1;
      sh2 <= sh1;
    end
  end

  // S3: magnitude or shifted filter value
  logic signed [TW-1:0] sq_a, sq_b;
  logic [TW-1:0]        mag_c;
  logic signed [SW-1:0] filt_c;
`ifdef CONV_ABS_MAG_EN
  logic [SW-1:0]        abs_a, abs_b;
  logic [SW:0]          abs_sum;
`endif
  always_comb begin
    sq_a   = {{(TW-SW){s2a[SW-1]}}, s2a};
    sq_b   = {{(TW-SW){s2b[SW-1]}}, s2b};
    mag_c  = sq_a * sq_a + sq_b * sq_b;
    filt_c = s2a >>> sh2;
`ifdef CONV_ABS_MAG_EN
    abs_a   = s2a[SW-1] ? -s2a : s2a;
    abs_b   = s2b[SW-1] ? -s2b : s2b;
    abs_sum = {1'b0, abs_a} + {1'b0, abs_b};
    if (op2 == OP_ABS)
      mag_c = {{(TW-SW-1){1'b0}}, abs_sum};
`endif
  end

  logic [TW-1:0]        m3;
  logic signed [SW-1:0] f3;
  always_ff @(posedge i_clk) begin
    if (v2) begin
      m3  <= mag_c;
      f3  <= filt_c;
      op3 <= op2;
      th3 <= th2;
    end
  end

  // S4: threshold or clamp
  logic [DW-1:0] out_c;
  always_comb begin
    out_c = '0;
    if (op3 == OP_FILT) begin
      if (f3[SW-1])
        out_c = '0;
      else if (|f3[SW-2:DW])
        out_c = '1;
      else
        out_c = f3[DW-1:0];
    end else begin
      out_c = (m3 > th3) ? '1 : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_data <= '0;
    else if (v3)
      o_data <= out_c;
  end

endmodule
